// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared memory0 port, with console IO decode and address range check.
// Define ARB_FIXED_PRIORITY_EN to make requester 0 win every tie instead of round-robin.
module mem_bus_arbiter #(
    parameter int unsigned MEMSIZE = 32'h7000,
    parameter int unsigned IOADDR  = 32'h7000,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        r0_req,
    input  logic        r0_rw,
    input  logic [1:0]  r0_size,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_ack,
    output logic        r0_err,
    output logic [31:0] r0_rdata,
    input  logic        r1_req,
    input  logic        r1_rw,
    input  logic [1:0]  r1_size,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_ack,
    output logic        r1_err,
    output logic [31:0] r1_rdata,
    output logic        m_en,
    output logic        m_rw,
    output logic [1:0]  m_size,
    output logic [31:0] mar,
    output logic [31:0] mdr,
    input  logic [31:0] dbus,
    output logic        io_we,
    output logic [31:0] io_data,
    output logic        owner,
    output logic        busy
);

    localparam logic [31:0] MaxAddr = 32'(MEMSIZE - 4);
    localparam logic [31:0] IoAddr  = 32'(IOADDR);
    localparam logic [3:0]  LatInit = 4'(MEM_LAT);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        owner_q, owner_d;
    logic        err_q, err_d;
    logic        m_en_q, m_en_d;
    logic        m_rw_q, m_rw_d;
    logic [1:0]  m_size_q, m_size_d;
    logic [31:0] mar_q, mar_d;
    logic [31:0] mdr_q, mdr_d;
    logic        io_we_q, io_we_d;
    logic [31:0] io_data_q, io_data_d;
    logic        r0_ack_q, r0_ack_d, r1_ack_q, r1_ack_d;
    logic        r0_err_q, r0_err_d, r1_err_q, r1_err_d;
    logic [31:0] r0_rdata_q, r0_rdata_d, r1_rdata_q, r1_rdata_d;

    logic        gnt_any, gnt_sel, sel_rw;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr, sel_wdata, sel_masked;

    always_comb begin
        gnt_any = r0_req | r1_req;
`ifdef ARB_FIXED_PRIORITY_EN
        gnt_sel = ~r0_req;
`else
        // On a tie, the requester not served last time wins.
        gnt_sel = (r0_req && r1_req) ? ~last_grant_q : ~r0_req;
`endif
        sel_rw    = gnt_sel ? r1_rw    : r0_rw;
        sel_size  = gnt_sel ? r1_size  : r0_size;
        sel_addr  = gnt_sel ? r1_addr  : r0_addr;
        sel_wdata = gnt_sel ? r1_wdata : r0_wdata;
        unique case (sel_size)
            2'b00:   sel_masked = {24'b0, sel_wdata[7:0]};
            2'b01:   sel_masked = {16'b0, sel_wdata[15:0]};
            2'b10:   sel_masked = {8'b0, sel_wdata[23:0]};
            default: sel_masked = sel_wdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        err_d        = err_q;
        m_en_d       = m_en_q;
        m_rw_d       = m_rw_q;
        m_size_d     = m_size_q;
        mar_d        = mar_q;
        mdr_d        = mdr_q;
        io_we_d      = 1'b0;
        io_data_d    = io_data_q;
        r0_ack_d     = 1'b0;
        r1_ack_d     = 1'b0;
        r0_err_d     = 1'b0;
        r1_err_d     = 1'b0;
        r0_rdata_d   = r0_rdata_q;
        r1_rdata_d   = r1_rdata_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_any) begin
                    owner_d      = gnt_sel;
                    last_grant_d = gnt_sel;
                    m_rw_d       = sel_rw;
                    m_size_d     = sel_size;
                    mar_d        = sel_addr;
                    mdr_d        = sel_wdata;
                    err_d        = 1'b0;
                    state_d      = StDone;
                    if (sel_addr == IoAddr) begin
                        if (!sel_rw) begin
                            io_we_d   = 1'b1;
                            io_data_d = sel_masked;
                        end else if (gnt_sel) begin
                            r1_rdata_d = '0;
                        end else begin
                            r0_rdata_d = '0;
                        end
                    end else if (sel_addr > MaxAddr) begin
                        err_d = 1'b1;
                        if (sel_rw && gnt_sel) r1_rdata_d = '0;
                        if (sel_rw && !gnt_sel) r0_rdata_d = '0;
                    end else begin
                        m_en_d  = 1'b1;
                        cnt_d   = LatInit;
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    m_en_d  = 1'b0;
                    state_d = StDone;
                    if (m_rw_q && owner_q) r1_rdata_d = dbus;
                    if (m_rw_q && !owner_q) r0_rdata_d = dbus;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (owner_q) begin
                    r1_ack_d = 1'b1;
                    r1_err_d = err_q;
                end else begin
                    r0_ack_d = 1'b1;
                    r0_err_d = err_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            err_q        <= 1'b0;
            m_en_q       <= 1'b0;
            m_rw_q       <= 1'b0;
            m_size_q     <= 2'b00;
            mar_q        <= '0;
            mdr_q        <= '0;
            io_we_q      <= 1'b0;
            io_data_q    <= '0;
            r0_ack_q     <= 1'b0;
            r1_ack_q     <= 1'b0;
            r0_err_q     <= 1'b0;
            r1_err_q     <= 1'b0;
            r0_rdata_q   <= '0;
            r1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            err_q        <= err_d;
            m_en_q       <= m_en_d;
            m_rw_q       <= m_rw_d;
            m_size_q     <= m_size_d;
            mar_q        <= mar_d;
            mdr_q        <= mdr_d;
            io_we_q      <= io_we_d;
            io_data_q    <= io_data_d;
            r0_ack_q     <= r0_ack_d;
            r1_ack_q     <= r1_ack_d;
            r0_err_q     <= r0_err_d;
            r1_err_q     <= r1_err_d;
            r0_rdata_q   <= r0_rdata_d;
            r1_rdata_q   <= r1_rdata_d;
        end
    end

    assign r0_ack   = r0_ack_q;
    assign r0_err   = r0_err_q;
    assign r0_rdata = r0_rdata_q;
    assign r1_ack   = r1_ack_q;
    assign r1_err   = r1_err_q;
    assign r1_rdata = r1_rdata_q;
    assign m_en     = m_en_q;
    assign m_rw     = m_rw_q;
    assign m_size   = m_size_q;
    assign mar      = mar_q;
    assign mdr      = mdr_q;
    assign io_we    = io_we_q;
    assign io_data  = io_data_q;
    assign owner    = owner_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed steps then random two-master traffic, checked against a
// transaction-level model of grant order, latency, classification and a byte-array memory.
module tb_mem_bus_arbiter;

    localparam int unsigned MEMSZ = 32'h7000;
    localparam int unsigned IOA   = 32'h7000;
    localparam int unsigned LAT   = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        r0_req, r0_rw, r1_req, r1_rw;
    logic [1:0]  r0_size, r1_size;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
    logic        r0_ack, r0_err, r1_ack, r1_err;
    logic [31:0] r0_rdata, r1_rdata;
    logic        m_en, m_rw, io_we, owner, busy;
    logic [1:0]  m_size;
    logic [31:0] mar, mdr, io_data;
    logic [31:0] dbus = '0;

    mem_bus_arbiter #(.MEMSIZE(MEMSZ), .IOADDR(IOA), .MEM_LAT(LAT)) dut (
        .clock(clock), .reset(reset),
        .r0_req(r0_req), .r0_rw(r0_rw), .r0_size(r0_size), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_rw(r1_rw), .r1_size(r1_size), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
        .m_en(m_en), .m_rw(m_rw), .m_size(m_size), .mar(mar), .mdr(mdr), .dbus(dbus),
        .io_we(io_we), .io_data(io_data), .owner(owner), .busy(busy)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            'h10: return 8'h44;
            'h11: return 8'h33;
            'h12: return 8'h22;
            'h13: return 8'h11;
            default: return 8'(i * 7 + 3);
        endcase
    endfunction

    // Memory device attached to the m_* port; little-endian, size-masked reads.
    logic [7:0] mem [MEMSZ];
    bit mem_ready = 1'b0;
    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < int'(MEMSZ); i++) mem[i] <= init_byte(i);
            mem_ready <= 1'b1;
        end else if (m_en && !m_rw) begin
            for (int b = 0; b <= int'(m_size); b++) mem[int'(mar) + b] <= mdr[8*b +: 8];
        end
    end
    always @(negedge clock) begin
        logic [31:0] v;
        v = '0;
        if (m_en) for (int b = 0; b <= int'(m_size); b++) v |= 32'(mem[int'(mar) + b]) << (8 * b);
        dbus <= v;
    end

    // Reference model state
    logic [7:0]  ref_mem [MEMSZ];
    logic        m_last;
    logic [31:0] m_rd [2];

    function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] v;
        v = '0;
        for (int b = 0; b <= int'(sz); b++) v |= 32'(ref_mem[int'(a) + b]) << (8 * b);
        return v;
    endfunction

    function automatic logic [31:0] io_mask(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd3) return wd;
        return wd & ((32'h1 << (8 * (int'(sz) + 1))) - 32'h1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pending request fields per requester
    logic        t_v  [2];
    logic        t_rw [2];
    logic [1:0]  t_sz [2];
    logic [31:0] t_ad [2];
    logic [31:0] t_wd [2];

    // Raise the valid requests together (DUT idle) and follow them to completion.
    task automatic run_pair();
        int n, first, last_c, id;
        int q [2];
        int g [2];
        int d [2];
        int kind [2];
        logic e_err [2];
        logic [31:0] e_rd [2];
        logic e_ack [2];
        logic e_men, e_iowe, e_busy, e_own;
        int ms, is;
        n = 0;
        if (t_v[0] && t_v[1]) begin
`ifdef ARB_FIXED_PRIORITY_EN
            first = 0;
`else
            first = m_last ? 0 : 1;
`endif
            q[0] = first;
            q[1] = 1 - first;
            n = 2;
        end else if (t_v[0]) begin
            q[0] = 0;
            n = 1;
        end else if (t_v[1]) begin
            q[0] = 1;
            n = 1;
        end
        if (n == 0) return;
        g[0] = 1;
        for (int k = 0; k < n; k++) begin
            id = q[k];
            if (t_ad[id] == IOA) kind[k] = 1;
            else if (t_ad[id] > MEMSZ - 4) kind[k] = 2;
            else kind[k] = 0;
            d[k] = (kind[k] == 0) ? int'(LAT) + 1 : 1;
            e_err[k] = (kind[k] == 2);
            if (t_rw[id]) begin
                m_rd[id] = (kind[k] == 0) ? ref_read(t_ad[id], t_sz[id]) : 32'h0;
            end else if (kind[k] == 0) begin
                for (int b = 0; b <= int'(t_sz[id]); b++)
                    ref_mem[int'(t_ad[id]) + b] = t_wd[id][8*b +: 8];
            end
            e_rd[k] = m_rd[id];
            m_last = id[0];
            if (k == 0 && n == 2) g[1] = g[0] + d[0] + 1;
        end
        last_c = g[n-1] + d[n-1];
        r0_req = t_v[0]; r0_rw = t_rw[0]; r0_size = t_sz[0]; r0_addr = t_ad[0]; r0_wdata = t_wd[0];
        r1_req = t_v[1]; r1_rw = t_rw[1]; r1_size = t_sz[1]; r1_addr = t_ad[1]; r1_wdata = t_wd[1];
        for (int c = 1; c <= last_c; c++) begin
            @(posedge clock);
            #1;
            e_ack[0] = 1'b0; e_ack[1] = 1'b0;
            e_men = 1'b0; e_iowe = 1'b0; e_busy = 1'b0; e_own = 1'b0;
            ms = 0; is = 0;
            for (int k = 0; k < n; k++) begin
                if (c == g[k] + d[k]) e_ack[q[k]] = 1'b1;
                if (kind[k] == 0 && c >= g[k] && c < g[k] + int'(LAT)) begin
                    e_men = 1'b1;
                    ms = q[k];
                end
                if (kind[k] == 1 && !t_rw[q[k]] && c == g[k]) begin
                    e_iowe = 1'b1;
                    is = q[k];
                end
                if (c >= g[k] && c < g[k] + d[k]) begin
                    e_busy = 1'b1;
                    e_own = q[k][0];
                end
            end
            chk("r0_ack", r0_ack, e_ack[0]);
            chk("r1_ack", r1_ack, e_ack[1]);
            chk("m_en", m_en, e_men);
            chk("io_we", io_we, e_iowe);
            chk("busy", busy, e_busy);
            if (e_busy) chk("owner", owner, e_own);
            if (e_men) begin
                chk("mar", mar, t_ad[ms]);
                chk("m_rw", m_rw, t_rw[ms]);
                chk("m_size", m_size, t_sz[ms]);
                if (!t_rw[ms]) chk("mdr", mdr, t_wd[ms]);
            end
            if (e_iowe) chk("io_data", io_data, io_mask(t_sz[is], t_wd[is]));
            for (int k = 0; k < n; k++) begin
                if (c == g[k] + d[k]) begin
                    if (q[k] == 0) begin
                        chk("r0_err", r0_err, e_err[k]);
                        chk("r0_rdata", r0_rdata, e_rd[k]);
                        r0_req = 1'b0;
                    end else begin
                        chk("r1_err", r1_err, e_err[k]);
                        chk("r1_rdata", r1_rdata, e_rd[k]);
                        r1_req = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic set_req(input int id, input logic rw, input logic [1:0] sz,
                           input logic [31:0] ad, input logic [31:0] wd);
        t_v[id] = 1'b1; t_rw[id] = rw; t_sz[id] = sz; t_ad[id] = ad; t_wd[id] = wd;
    endtask

    initial begin
        int r;
        reset = 1'b1;
        r0_req = 0; r0_rw = 0; r0_size = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_rw = 0; r1_size = 0; r1_addr = 0; r1_wdata = 0;
        for (int i = 0; i < int'(MEMSZ); i++) ref_mem[i] = init_byte(i);
        m_last = 1'b1;
        m_rd[0] = '0; m_rd[1] = '0;
        t_v[0] = 1'b0; t_v[1] = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_m_en", m_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_acks", {r0_ack, r1_ack, r0_err, r1_err, io_we, m_rw, owner}, 0);
        chk("rst_m_size", m_size, 0);
        chk("rst_mar", mar, 0);
        chk("rst_mdr", mdr, 0);
        chk("rst_io_data", io_data, 0);
        chk("rst_rdata", r0_rdata | r1_rdata, 0);
        reset = 1'b0;

        // Word read, byte write then byte read-back
        t_v[0] = 0; t_v[1] = 0; set_req(0, 1'b1, 2'b11, 32'h10, 32'h0);
        run_pair();
        chk("word_read", r0_rdata, 32'h11223344);
        t_v[0] = 0; t_v[1] = 0; set_req(1, 1'b0, 2'b00, 32'h20, 32'hA5);
        run_pair();
        t_v[0] = 0; t_v[1] = 0; set_req(1, 1'b1, 2'b00, 32'h20, 32'h0);
        run_pair();
        chk("byte_readback", r1_rdata, 32'h000000A5);

        // Continuous contention
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b1, 2'b11, 32'h30, 32'h0);
            set_req(1, 1'b0, 2'b01, 32'h34, 32'h1234 + i);
            run_pair();
        end

        // Console write, then out-of-range read
        t_v[0] = 0; t_v[1] = 0; set_req(0, 1'b0, 2'b11, IOA, 32'h00006948);
        run_pair();
        t_v[0] = 0; t_v[1] = 0; set_req(1, 1'b1, 2'b11, 32'h6FFE, 32'h0);
        run_pair();
        chk("err_rdata", r1_rdata, 32'h0);

        // Reset in the middle of a memory access
        r0_req = 1; r0_rw = 1; r0_size = 2'b11; r0_addr = 32'h40; r1_req = 0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        chk("pre_rst_m_en", m_en, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_m_en", m_en, 0);
        chk("mid_rst_busy", busy, 0);
        r0_req = 0;
        @(posedge clock);
        #1;
        chk("mid_rst_no_ack", r0_ack, 0);
        reset = 1'b0;
        m_last = 1'b1;
        m_rd[0] = '0; m_rd[1] = '0;
        set_req(0, 1'b1, 2'b00, 32'h41, 32'h0);
        set_req(1, 1'b1, 2'b00, 32'h42, 32'h0);
        run_pair();

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            for (int id = 0; id < 2; id++) begin
                t_v[id]  = 1'($urandom_range(0, 1));
                t_rw[id] = 1'($urandom_range(0, 1));
                t_sz[id] = 2'($urandom_range(0, 3));
                t_wd[id] = $urandom;
                r = $urandom_range(0, 9);
                if (r == 0) t_ad[id] = IOA;
                else if (r == 1) t_ad[id] = MEMSZ - 4;
                else if (r == 2) t_ad[id] = MEMSZ - 3 + $urandom_range(0, 64);
                else t_ad[id] = 32'h40 + $urandom_range(0, 15);
            end
            if (!t_v[0] && !t_v[1]) t_v[0] = 1'b1;
            run_pair();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
